// File: rtl/horizontal_tf_sched_pkg.sv
// Shared constants for the horizontal twiddle-factor sequencer,
// its datapath and the top-level stage FSM.
package horizontal_tf_sched_pkg;

    localparam int S_WIDTH = 4;
    localparam int P_WIDTH = 64;

    localparam logic [S_WIDTH-1:0] STAGE_IDLE = 4'd15;

    typedef logic [2:0] htf_state_t;

    localparam htf_state_t ST_IDLE  = 3'd0;
    localparam htf_state_t ST_PRIME = 3'd1;
    localparam htf_state_t ST_RUN   = 3'd2;
    localparam htf_state_t ST_DRAIN = 3'd3;
    localparam htf_state_t ST_DONE  = 3'd4;

endpackage

// File: rtl/horizontal_tf_sched_group_counter.sv
// Group position and block counter for one horizontal pass.
// wrap flags group_cnt==15, last flags the final block.
module htf_group_counter
    import horizontal_tf_sched_pkg::*;
#(
    parameter int NUM_BLK = 64,
    parameter int BLK_W   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       hold,
    output logic [3:0] group_cnt,
    output logic       wrap,
    output logic       last
);

    logic [BLK_W-1:0] blk;

    assign wrap = (group_cnt == 4'd15);
    assign last = (blk == BLK_W'(NUM_BLK - 1));

    // Advance position every unstalled cycle; block steps on wrap.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            group_cnt <= 4'd0;
            blk       <= '0;
        end else if (clear) begin
            group_cnt <= 4'd0;
            blk       <= '0;
        end else if (!hold) begin
            group_cnt <= group_cnt + 4'd1;
            if (wrap) begin
                blk <= blk + BLK_W'(1);
            end
        end
    end

endmodule

// File: rtl/horizontal_tf_sched.sv
// Horizontal twiddle-factor sequencer: PRIME, RUN, DRAIN, DONE.
// Optional abort path is built when HTF_ABORT_EN is defined.
module horizontal_tf_sched
    import horizontal_tf_sched_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int NUM_BLK = 64,
    parameter int BLK_W   = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       hold,
`ifdef HTF_ABORT_EN
    input  logic       abort,
    output logic       abort_ack,
`endif
    output logic       CEN,
    output logic [3:0] stage_counter,
    output logic [3:0] group_cnt,
    output logic [1:0] tf_order_cnt,
    output logic       const_load,
    output logic       base_sel,
    output logic       horizontal_en,
    output logic       busy,
    output logic       done
);

    localparam int D_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [D_W-1:0] D_LAST = D_W'(MUL_LAT - 1);

    htf_state_t state;
    htf_state_t state_nx;

    logic           run;
    logic           adv;
    logic           wrap;
    logic           last;
    logic           exit_run;
    logic           clr;
    logic           abort_hit;
    logic           cen_q;
    logic           cl_q;
    logic           hen_q;
    logic           done_q;
    logic [D_W-1:0] dcnt;

`ifdef HTF_ABORT_EN
    assign abort_hit = abort && (state != ST_IDLE);
`else
    assign abort_hit = 1'b0;
`endif

    assign run      = (state == ST_RUN);
    assign adv      = run && !hold;
    assign exit_run = adv && wrap && last;
    assign clr      = !run || abort_hit || exit_run;

    htf_group_counter #(
        .NUM_BLK (NUM_BLK),
        .BLK_W   (BLK_W)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clr),
        .hold      (hold),
        .group_cnt (group_cnt),
        .wrap      (wrap),
        .last      (last)
    );

    // Next-state selection; abort overrides every other transition.
    always_comb begin
        state_nx = state;
        if (abort_hit) begin
            state_nx = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:  if (start) state_nx = ST_PRIME;
                ST_PRIME: state_nx = ST_RUN;
                ST_RUN:   if (exit_run) state_nx = ST_DRAIN;
                ST_DRAIN: if (dcnt == D_LAST) state_nx = ST_DONE;
                ST_DONE:  state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end
    end

    // State and registered control outputs.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state  <= ST_IDLE;
            cen_q  <= 1'b1;
            cl_q   <= 1'b0;
            hen_q  <= 1'b0;
            done_q <= 1'b0;
            dcnt   <= '0;
        end else begin
            state  <= state_nx;
            cen_q  <= !(state_nx == ST_PRIME || state_nx == ST_RUN);
            cl_q   <= (state_nx == ST_RUN) &&
                      (!run || (adv ? wrap : (group_cnt == 4'd0)));
            done_q <= (state_nx == ST_DONE);
            if (state == ST_DRAIN && state_nx == ST_DRAIN) begin
                dcnt <= dcnt + D_W'(1);
            end else begin
                dcnt <= '0;
            end
            if (state_nx == ST_DONE || state_nx == ST_IDLE) begin
                hen_q <= 1'b0;
            end else if (run && group_cnt == 4'd2) begin
                hen_q <= 1'b1;
            end
        end
    end

`ifdef HTF_ABORT_EN
    // One-cycle acknowledge of an accepted abort.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            abort_ack <= 1'b0;
        end else begin
            abort_ack <= abort_hit;
        end
    end
`endif

    // A stall takes effect in the cycle hold is raised.
    assign CEN           = cen_q || (run && hold);
    assign const_load    = cl_q && !hold;
    assign horizontal_en = hen_q;
    assign done          = done_q;
    assign tf_order_cnt  = group_cnt[3:2];
    assign base_sel      = (group_cnt[3:2] == 2'd0);
    assign busy          = (state != ST_IDLE);
    assign stage_counter = (state == ST_PRIME || state == ST_RUN ||
                            state == ST_DRAIN) ? 4'd0 : STAGE_IDLE;

endmodule

// File: tb/tb_horizontal_tf_sched.sv
// Bench for horizontal_tf_sched: directed timeline checks plus
// randomized start/hold/reset traffic against a pass-level model.
module tb_horizontal_tf_sched;

    localparam int NB = 2;
    localparam int ML = 4;
    localparam int NC = 80;

    typedef bit bv_t[NC];

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic       hold = 1'b0;
`ifdef HTF_ABORT_EN
    logic       abort = 1'b0;
    logic       abort_ack;
`endif
    logic       CEN;
    logic [3:0] stage_counter;
    logic [3:0] group_cnt;
    logic [1:0] tf_order_cnt;
    logic       const_load;
    logic       base_sel;
    logic       horizontal_en;
    logic       busy;
    logic       done;

    horizontal_tf_sched #(
        .MUL_LAT (ML),
        .NUM_BLK (NB),
        .BLK_W   (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .hold          (hold),
`ifdef HTF_ABORT_EN
        .abort         (abort),
        .abort_ack     (abort_ack),
`endif
        .CEN           (CEN),
        .stage_counter (stage_counter),
        .group_cnt     (group_cnt),
        .tf_order_cnt  (tf_order_cnt),
        .const_load    (const_load),
        .base_sel      (base_sel),
        .horizontal_en (horizontal_en),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0d exp=%0d", nm, cyc, act, exp);
        end
    endtask

    // Pass-level model: phase 0 idle, 1 prime, 2 run, 3 drain, 4 done.
    // k counts unstalled RUN cycles completed, dr counts DRAIN cycles.
    int ph = 0;
    int k = 0;
    int dr = 0;
    bit hen_f = 0;
    bit ack_f = 0;

    always @(negedge clk) begin
        int  gce;
        bit  ab;
        if (rst_n) begin
            ph = 0; k = 0; dr = 0; hen_f = 0; ack_f = 0;
        end
`ifdef HTF_ABORT_EN
        ab = abort;
`else
        ab = 1'b0;
`endif
        gce = (ph == 2) ? (k % 16) : 0;
        chk("cen", int'(CEN), int'(!(ph == 1 || (ph == 2 && !hold))));
        chk("stage", int'(stage_counter), (ph >= 1 && ph <= 3) ? 0 : 15);
        chk("group_cnt", int'(group_cnt), gce);
        chk("tf_order", int'(tf_order_cnt), gce / 4);
        chk("const_load", int'(const_load),
            int'(ph == 2 && !hold && gce == 0));
        chk("base_sel", int'(base_sel), int'(gce < 4));
        chk("hen", int'(horizontal_en), int'(hen_f));
        chk("busy", int'(busy), int'(ph != 0));
        chk("done", int'(done), int'(ph == 4));
`ifdef HTF_ABORT_EN
        chk("abort_ack", int'(abort_ack), int'(ack_f));
`endif
        if (!rst_n) begin
            ack_f = 0;
            if (ab && ph != 0) begin
                ph = 0; hen_f = 0; ack_f = 1;
            end else begin
                case (ph)
                    0: if (start) ph = 1;
                    1: begin ph = 2; k = 0; end
                    2: begin
                        if (k % 16 == 2) hen_f = 1;
                        if (!hold) begin
                            k++;
                            if (k == 16 * NB) begin ph = 3; dr = 0; end
                        end
                    end
                    3: begin
                        dr++;
                        if (dr == ML) begin ph = 4; hen_f = 0; end
                    end
                    default: ph = 0;
                endcase
            end
        end
    end

    bv_t cen_a, hen_a, done_a, busy_a, cl_a, base_a, ack_a;
    int  gc_a[NC];
    int  st_a[NC];

    function automatic int first_one(input bv_t a);
        for (int i = 0; i < NC; i++) if (a[i]) return i;
        return -1;
    endfunction

    function automatic int count_in(input bv_t a, input int lo, input int hi);
        int n = 0;
        for (int i = lo; i <= hi; i++) if (a[i]) n++;
        return n;
    endfunction

    // kind 0 nominal, 1 hold, 2 reset mid-pass, 3 stray starts, 4 abort
    task automatic scen(input int kind);
        for (int c = 0; c < NC; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (kind == 2 && c == 25) ||
                    (kind == 3 && (c == 10 || c == 35));
            hold  = (kind == 1 && c >= 10 && c <= 12);
            rst_n = (kind == 2 && c == 20);
`ifdef HTF_ABORT_EN
            abort = (kind == 4 && c == 15);
`endif
            @(negedge clk);
            cen_a[c]  = CEN;
            hen_a[c]  = horizontal_en;
            done_a[c] = done;
            busy_a[c] = busy;
            cl_a[c]   = const_load;
            base_a[c] = base_sel;
            gc_a[c]   = int'(group_cnt);
            st_a[c]   = int'(stage_counter);
`ifdef HTF_ABORT_EN
            ack_a[c]  = abort_ack;
`else
            ack_a[c]  = 1'b0;
`endif
        end
        @(posedge clk); #1;
        start = 0; hold = 0; rst_n = 0;
`ifdef HTF_ABORT_EN
        abort = 0;
`endif
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        repeat (2) @(posedge clk);

        scen(0);
        chk("nom_cen_c0", int'(cen_a[0]), 1);
        chk("nom_cen_c1", int'(cen_a[1]), 0);
        chk("nom_cen_c33", int'(cen_a[33]), 0);
        chk("nom_cen_c34", int'(cen_a[34]), 1);
        chk("nom_cen_low_cnt", NC - count_in(cen_a, 0, NC - 1), 33);
        chk("nom_hen_first", first_one(hen_a), 5);
        chk("nom_hen_cnt", count_in(hen_a, 0, NC - 1), 33);
        chk("nom_hen_c38", int'(hen_a[38]), 0);
        chk("nom_done_at", first_one(done_a), 38);
        chk("nom_done_cnt", count_in(done_a, 0, NC - 1), 1);
        chk("nom_busy_c38", int'(busy_a[38]), 1);
        chk("nom_busy_c39", int'(busy_a[39]), 0);
        chk("nom_cl_c2", int'(cl_a[2]), 1);
        chk("nom_cl_c18", int'(cl_a[18]), 1);
        chk("nom_cl_cnt", count_in(cl_a, 0, NC - 1), 2);
        chk("nom_base_run_cnt", count_in(base_a, 2, 33), 8);
        chk("nom_gc_c6", gc_a[6], 4);
        chk("nom_gc_c33", gc_a[33], 15);
        chk("nom_stage_c34", st_a[34], 0);
        chk("nom_stage_c38", st_a[38], 15);

        scen(1);
        chk("hold_cen_c9", int'(cen_a[9]), 0);
        chk("hold_cen_cnt", count_in(cen_a, 10, 12), 3);
        chk("hold_cen_c13", int'(cen_a[13]), 0);
        for (int c = 10; c <= 13; c++) chk("hold_gc_frozen", gc_a[c], 8);
        chk("hold_gc_c14", gc_a[14], 9);
        chk("hold_done_at", first_one(done_a), 41);

        scen(2);
        chk("rst_cen", int'(cen_a[20]), 1);
        chk("rst_busy", int'(busy_a[20]), 0);
        chk("rst_hen", int'(hen_a[20]), 0);
        chk("rst_gc", gc_a[20], 0);
        chk("rst_stage", st_a[20], 15);
        chk("rst_base", int'(base_a[20]), 1);
        chk("rst_done_at", first_one(done_a), 63);
        chk("rst_done_cnt", count_in(done_a, 0, NC - 1), 1);

        scen(3);
        chk("stray_done_at", first_one(done_a), 38);
        chk("stray_done_cnt", count_in(done_a, 0, NC - 1), 1);

`ifdef HTF_ABORT_EN
        scen(4);
        chk("abort_ack_c16", int'(ack_a[16]), 1);
        chk("abort_ack_cnt", count_in(ack_a, 0, NC - 1), 1);
        chk("abort_busy_c16", int'(busy_a[16]), 0);
        chk("abort_cen_c16", int'(cen_a[16]), 1);
        chk("abort_done_cnt", count_in(done_a, 0, NC - 1), 0);
`endif

        for (int i = 0; i < 4000; i++) begin
            @(posedge clk); #1;
            start = ($urandom % 6 == 0);
            hold  = ($urandom % 4 == 0);
            rst_n = ($urandom % 400 == 0);
`ifdef HTF_ABORT_EN
            abort = ($urandom % 120 == 0);
`endif
        end
        @(posedge clk); #1;
        start = 0; hold = 0; rst_n = 0;
`ifdef HTF_ABORT_EN
        abort = 0;
`endif
        repeat (2) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
